// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
// Source IDs tag each outstanding read so its response returns to the right cache.
// The grant helper encodes the round-robin tie-break in one place.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 128;
  localparam int MAX_OUT_DEF = 4;

  // Source IDs stored in the response-routing FIFO
  localparam logic SRC_ICACHE = 1'b0;
  localparam logic SRC_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_IC   = 2'd1,
    WIN_DC   = 2'd2
  } winner_e;

  // A lone eligible requester wins; on a tie the one not granted last time wins.
  function automatic winner_e pick_winner(input logic ic_elig,
                                          input logic dc_elig,
                                          input logic last_grant);
    winner_e w;
    w = WIN_NONE;
    if (ic_elig && dc_elig) begin
      if (last_grant == SRC_DCACHE) w = WIN_IC;
      else                          w = WIN_DC;
    end else if (ic_elig) begin
      w = WIN_IC;
    end else if (dc_elig) begin
      w = WIN_DC;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the icache, dcache and memory-side signals of the arbiter.
// slave: the arbiter's view; master: the environment (caches + memory).
// Pure wiring, no timing of its own.
interface mem_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 4
) ();
  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;

  logic              dc_req_valid;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_data;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  logic [OUT_W-1:0]  outstanding;
  logic              spurious_err;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output outstanding, spurious_err
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  outstanding, spurious_err
  );
endinterface

// File: rtl/mem_arbiter_src_id_fifo.sv
// Width-1 synchronous FIFO holding the source ID of each in-flight read.
// dout shows the head combinationally; push/pop take effect at the next edge.
// Push while full and pop while empty are ignored; the caller gates on full/empty.
module src_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state: pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache.
// Grant and response routing are combinational: zero added latency either way.
// Reads stall while MAX_OUT are in flight; posted writes are never blocked by that.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int OUT_W = $clog2(MAX_OUT) + 1;

  logic             fifo_full, fifo_empty, fifo_dout;
  logic             fifo_push, fifo_pop, fifo_din;
  logic [OUT_W-1:0] fifo_count;
  logic             last_grant_q, last_grant_d;
  logic             spurious_q, spurious_d;
  logic             ic_elig, dc_elig, accept;
  winner_e          winner;

  // Eligibility uses the pre-pop fill level, so a read waits a cycle after a full-cycle pop
  always_comb begin
    ic_elig = bus.ic_req_valid && !fifo_full && !reset;
    dc_elig = bus.dc_req_valid && (bus.dc_req_rw || !fifo_full) && !reset;
    winner  = pick_winner(ic_elig, dc_elig, last_grant_q);
  end

  // Forward the winner's request to memory and return ready only to the winner
  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_data  = '0;
    bus.ic_req_ready  = 1'b0;
    bus.dc_req_ready  = 1'b0;
    case (winner)
      WIN_IC: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = bus.ic_req_addr;
        bus.ic_req_ready  = bus.mem_req_ready;
      end
      WIN_DC: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = bus.dc_req_rw;
        bus.mem_req_addr  = bus.dc_req_addr;
        bus.mem_req_data  = bus.dc_req_data;
        bus.dc_req_ready  = bus.mem_req_ready;
      end
      default: ;
    endcase
    accept    = bus.mem_req_valid && bus.mem_req_ready;
    fifo_push = accept && !bus.mem_req_rw;
    fifo_din  = (winner == WIN_DC) ? SRC_DCACHE : SRC_ICACHE;
  end

  // Route each memory response to the cache recorded at the FIFO head
  always_comb begin
    fifo_pop          = bus.mem_resp_valid && !fifo_empty && !reset;
    bus.ic_resp_valid = fifo_pop && (fifo_dout == SRC_ICACHE);
    bus.dc_resp_valid = fifo_pop && (fifo_dout == SRC_DCACHE);
    bus.ic_resp_data  = bus.ic_resp_valid ? bus.mem_resp_data : '0;
    bus.dc_resp_data  = bus.dc_resp_valid ? bus.mem_resp_data : '0;
  end

  // Round-robin pointer moves only on acceptance; spurious flag is sticky
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = (winner == WIN_DC) ? SRC_DCACHE : SRC_ICACHE;
    spurious_d = spurious_q || (bus.mem_resp_valid && fifo_empty);
  end

  // Arbiter state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SRC_ICACHE;
      spurious_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      spurious_q   <= spurious_d;
    end
  end

  assign bus.outstanding  = fifo_count;
  assign bus.spurious_err = spurious_q;

  src_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_src_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
